// File: rtl/l1d_evict_wb_buffer.sv
// l1d_evict_wb_buffer: collects evicted dirty-line beats from the L1D data pipe into
// NUM_ENTRIES line buffers and drains them in fill order over a vld/rdy write-back port.
module l1d_evict_wb_buffer #(
  parameter  int DATA_WIDTH  = 64,
  parameter  int BEATS       = 4,
  parameter  int NUM_ENTRIES = 2,
  parameter  int TAG_WIDTH   = 20,
  parameter  int INDEX_WIDTH = 6,
  parameter  int ID_WIDTH    = 4,
  localparam int OFS_W       = $clog2(BEATS),
  localparam int PTR_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 evict_beat_vld,
  input  logic [TAG_WIDTH-1:0]                 evict_beat_tag,
  input  logic [INDEX_WIDTH-1:0]               evict_beat_index,
  input  logic                                 evict_beat_last,
  input  logic [ID_WIDTH-1:0]                  evict_beat_id,
  input  logic [DATA_WIDTH-1:0]                evict_beat_data,
  output logic                                 buf_avail,
  output logic                                 wb_vld,
  input  logic                                 wb_rdy,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFS_W-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]                wb_data,
  output logic                                 wb_last,
  output logic [ID_WIDTH-1:0]                  wb_id,
  output logic                                 evict_done_en,
  output logic [ID_WIDTH-1:0]                  evict_done_id,
  output logic                                 overflow_err
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
    logic [ID_WIDTH-1:0]    id;
  } meta_t;

  typedef enum logic [1:0] {IDLE, SEND, DONE} st_t;

  logic [NUM_ENTRIES-1:0][BEATS-1:0][DATA_WIDTH-1:0] line_data;
  meta_t [NUM_ENTRIES-1:0]                           line_meta;
  logic  [NUM_ENTRIES-1:0]                           full;
  logic  [PTR_W-1:0]                                 fill_ptr, drain_ptr;
  logic  [OFS_W-1:0]                                 beat_cnt, wb_cnt;
  st_t                                               state;
  meta_t                                             cur_meta;
  logic                                              fill_en, beat_end;

  // The entry being drained stays owned by the drain side until DONE frees it.
  assign buf_avail = !full[fill_ptr] && !((state != IDLE) && (drain_ptr == fill_ptr));
  assign fill_en   = evict_beat_vld && buf_avail;
  assign beat_end  = (beat_cnt == OFS_W'(BEATS - 1));

  // Line storage: payload needs no reset, only the full flags qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_data[fill_ptr][beat_cnt] <= evict_beat_data;
      if (beat_cnt == '0)
        line_meta[fill_ptr] <= '{tag: evict_beat_tag, index: evict_beat_index, id: evict_beat_id};
    end
  end

  // Fill side bookkeeping: beat counter, fill pointer, full flags, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr     <= '0;
      beat_cnt     <= '0;
      full         <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (state == DONE)
        full[drain_ptr] <= 1'b0;
      if (fill_en) begin
        if (evict_beat_last) begin
          // A short line is still closed so the MSHR handshake completes.
          full[fill_ptr] <= 1'b1;
          fill_ptr       <= fill_ptr + PTR_W'(1);
          beat_cnt       <= '0;
          if (!beat_end) overflow_err <= 1'b1;
        end else if (beat_end) begin
          // Missing last: restart the line in place rather than spill into the next entry.
          beat_cnt     <= '0;
          overflow_err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + OFS_W'(1);
        end
      end else if (evict_beat_vld) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Drain FSM: IDLE waits for the head entry, SEND streams beats, DONE frees and reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_ptr <= '0;
      wb_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (full[drain_ptr]) begin
          state  <= SEND;
          wb_cnt <= '0;
        end
        SEND: if (wb_rdy) begin
          if (wb_cnt == OFS_W'(BEATS - 1)) state <= DONE;
          else                              wb_cnt <= wb_cnt + OFS_W'(1);
        end
        DONE: begin
          drain_ptr <= drain_ptr + PTR_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_meta      = line_meta[drain_ptr];
  assign wb_vld        = (state == SEND);
  assign wb_last       = (state == SEND) && (wb_cnt == OFS_W'(BEATS - 1));
  assign wb_addr       = {cur_meta.tag, cur_meta.index, wb_cnt};
  assign wb_data       = line_data[drain_ptr][wb_cnt];
  assign wb_id         = cur_meta.id;
  assign evict_done_en = (state == DONE);
  assign evict_done_id = cur_meta.id;

endmodule

// File: tb/tb_l1d_evict_wb_buffer.sv
// Directed bench for l1d_evict_wb_buffer with a write-back / done scoreboard.
module tb_l1d_evict_wb_buffer;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evict_beat_vld = 1'b0;
  logic [19:0]   evict_beat_tag = '0;
  logic [5:0]    evict_beat_index = '0;
  logic          evict_beat_last = 1'b0;
  logic [3:0]    evict_beat_id = '0;
  logic [63:0]   evict_beat_data = '0;
  logic          buf_avail, wb_vld, wb_last, evict_done_en, overflow_err;
  logic          wb_rdy = 1'b1;
  logic [AW-1:0] wb_addr;
  logic [63:0]   wb_data;
  logic [3:0]    wb_id, evict_done_id;

  l1d_evict_wb_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .evict_beat_vld(evict_beat_vld), .evict_beat_tag(evict_beat_tag),
    .evict_beat_index(evict_beat_index), .evict_beat_last(evict_beat_last),
    .evict_beat_id(evict_beat_id), .evict_beat_data(evict_beat_data),
    .buf_avail(buf_avail), .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_last(wb_last), .wb_id(wb_id),
    .evict_done_en(evict_done_en), .evict_done_id(evict_done_id),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    bit            dv;
    bit            last;
    logic [3:0]    id;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] done_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         rdy_mode = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // wb_rdy patterns: 0 always ready, 1 repeating 1,0,0,1, 2 held low
  initial begin
    logic [3:0] pat;
    int pi;
    pat = 4'b1001;
    pi  = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       wb_rdy = 1'b1;
        1:       begin wb_rdy = pat[3 - pi]; pi = (pi + 1) % 4; end
        default: wb_rdy = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    bit            stall_prev;
    logic [AW-1:0] p_addr;
    logic [63:0]   p_data;
    logic          p_last;
    logic [3:0]    p_id;
    exp_t          e;
    logic [3:0]    did;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          chk("wb_stall_hold", {wb_vld, wb_addr, wb_data, wb_last, wb_id},
                               {1'b1, p_addr, p_data, p_last, p_id});
        if (wb_vld === 1'b1 && wb_rdy) begin
          chk("wb_beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_addr", wb_addr, e.addr);
            if (e.dv) chk("wb_data", wb_data, e.data);
            chk("wb_last", wb_last, e.last);
            chk("wb_id", wb_id, e.id);
          end
        end
        if (evict_done_en === 1'b1) begin
          chk("done_expected", done_q.size() > 0, 1);
          if (done_q.size() > 0) begin
            did = done_q.pop_front();
            chk("done_id", evict_done_id, did);
          end
        end
        stall_prev = (wb_vld === 1'b1) && !wb_rdy;
        p_addr = wb_addr; p_data = wb_data; p_last = wb_last; p_id = wb_id;
      end
    end
  end

  initial begin : stim
    int n;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_wb_last", wb_last, 0);
    chk("rst_done_en", evict_done_en, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_buf_avail", buf_avail, 1);

    // single line, always ready, check fill-to-drain latency
    @(posedge clk); #1;
    drive_line(20'h12345, 6'd5, 4'd3, 64'hA0, 4, 1'b1);
    @(negedge clk);
    chk("lat_vld_low", wb_vld, 0);
    @(negedge clk);
    chk("lat_vld_high", wb_vld, 1);
    wait_drain(200);
    chk("line1_no_err", overflow_err, 0);

    // same line with stalls 1,0,0,1
    rdy_mode = 1;
    @(posedge clk); #1;
    drive_line(20'h12345, 6'd5, 4'd3, 64'hA0, 4, 1'b1);
    wait_drain(200);
    rdy_mode = 0;

    // two lines held back, third line dropped
    rdy_mode = 2;
    @(posedge clk); #1;
    drive_line(20'h00111, 6'd1, 4'd1, 64'h100, 4, 1'b1);
    drive_line(20'h00222, 6'd2, 4'd2, 64'h200, 4, 1'b1);
    @(negedge clk);
    chk("full_buf_avail", buf_avail, 0);
    @(posedge clk); #1;
    drive_line(20'h00333, 6'd3, 4'd7, 64'h300, 4, 1'b0);
    @(negedge clk);
    chk("drop_overflow", overflow_err, 1);
    repeat (12) @(posedge clk);
    #1 rdy_mode = 0;
    wait_drain(200);
    chk("drop_overflow_sticky", overflow_err, 1);
    chk("drop_buf_avail_back", buf_avail, 1);

    // short line: last on 2nd beat
    do_reset();
    @(negedge clk);
    chk("short_pre_err", overflow_err, 0);
    @(posedge clk); #1;
    drive_line(20'h0ABCD, 6'd9, 4'd6, 64'h5500, 2, 1'b1);
    @(negedge clk);
    chk("short_overflow", overflow_err, 1);
    wait_drain(200);

    // reset mid-drain after beat 1 accepted
    do_reset();
    @(posedge clk); #1;
    drive_line(20'h0BEEF, 6'd4, 4'd9, 64'h900, 4, 1'b1);
    n = 0;
    @(negedge clk);
    while (wb_vld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("middrain_vld_seen", n < 50, 1);
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("middrain_rst_vld", wb_vld, 0);
    chk("middrain_rst_done", evict_done_en, 0);
    exp_q.delete(); done_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("middrain_buf_avail", buf_avail, 1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (wb_vld !== 1'b0 || evict_done_en !== 1'b0) n++;
    end
    chk("middrain_no_stale", n, 0);
    mon_en = 1'b1;

    // fill entry 1 while entry 0 drains, then wrap both pointers
    @(posedge clk); #1;
    drive_line(20'h01111, 6'd10, 4'd5, 64'hC00, 4, 1'b1);
    drive_line(20'h02222, 6'd11, 4'd6, 64'hD00, 4, 1'b1);
    wait_drain(200);
    @(posedge clk); #1;
    drive_line(20'h03333, 6'd12, 4'd7, 64'hE00, 4, 1'b1);
    wait_drain(200);
    chk("wrap_buf_avail", buf_avail, 1);
    chk("wrap_no_err", overflow_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    evict_beat_vld = 1'b0;
    evict_beat_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); done_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic drive_line(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] id,
                            input logic [63:0] base, input int nb, input bit push);
    exp_t e;
    if (push) begin
      for (int b = 0; b < 4; b++) begin
        e.addr = {tag, idx, 2'(b)};
        e.data = base + 64'(b);
        e.dv   = (b < nb);
        e.last = (b == 3);
        e.id   = id;
        exp_q.push_back(e);
      end
      done_q.push_back(id);
    end
    for (int b = 0; b < nb; b++) begin
      evict_beat_vld   = 1'b1;
      evict_beat_tag   = tag;
      evict_beat_index = idx;
      evict_beat_id    = id;
      evict_beat_data  = base + 64'(b);
      evict_beat_last  = (b == nb - 1);
      @(posedge clk); #1;
    end
    evict_beat_vld  = 1'b0;
    evict_beat_last = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < budget, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

endmodule
